// File: rtl/tpu_result_tx.sv
// tpu_result_tx
// Return-path responder for the MLP. It snapshots the MLP status (state, cycle
// count, acc0) and streams it to the UART TX byte interface as a fixed 8-byte
// frame:
//   A5 | {3'b0,cnt} | {4'h0,state} | acc[7:0] | acc[15:8] | acc[23:16] |
//   acc[31:24] | XOR of bytes 1..6
// A frame is sent on a manual request from the UART controller, or
// automatically when the MLP enters DONE_STATE (if auto_en is set).
//
// Ports:
//   clk, rst          - system clock, asynchronous active-high reset
//   result_req        - single-cycle manual request for one frame
//   auto_en           - enables auto-send on entry into DONE_STATE
//   mlp_state_in      - MLP FSM state (4 bits)
//   mlp_cycle_cnt_in  - MLP cycle counter (5 bits)
//   mlp_acc0_in       - MLP accumulator result (32 bits, signed)
//   tx_data/tx_valid  - byte to the UART TX, valid flag
//   tx_ready          - UART TX accepts the presented byte
//   busy              - frame in progress
//   frame_done        - one-cycle pulse after the last byte is accepted
//   req_dropped       - one-cycle pulse when result_req arrives while busy
module tpu_result_tx #(
  parameter logic [7:0] SYNC_BYTE  = 8'hA5,
  parameter logic [3:0] DONE_STATE = 4'd8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        result_req,
  input  logic        auto_en,
  input  logic [3:0]  mlp_state_in,
  input  logic [4:0]  mlp_cycle_cnt_in,
  input  logic [31:0] mlp_acc0_in,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        busy,
  output logic        frame_done,
  output logic        req_dropped
);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [2:0]  idx_q, idx_d;
  logic        pending_q, pending_d;
  logic [3:0]  prev_state_q;
  logic [3:0]  snap_state_q;
  logic [4:0]  snap_cnt_q;
  logic [31:0] snap_acc_q;
  logic        load_snap;
  logic        frame_done_d;
  logic        req_dropped_d;
  logic        auto_trig;
  logic [7:0]  checksum;
  logic [7:0]  byte_sel;

  // Auto trigger fires only on the cycle the MLP first shows DONE_STATE, so a
  // state parked at DONE_STATE produces a single frame.
  assign auto_trig = auto_en && (mlp_state_in == DONE_STATE) &&
                     (prev_state_q != DONE_STATE);

  // Checksum comes from the snapshot so live input changes mid-frame cannot
  // disturb it.
  assign checksum = {3'b000, snap_cnt_q} ^ {4'h0, snap_state_q} ^
                    snap_acc_q[7:0] ^ snap_acc_q[15:8] ^
                    snap_acc_q[23:16] ^ snap_acc_q[31:24];

  // Byte multiplexer selecting the frame byte for the current index.
  always_comb begin
    byte_sel = 8'h00;
    case (idx_q)
      3'd0: byte_sel = SYNC_BYTE;
      3'd1: byte_sel = {3'b000, snap_cnt_q};
      3'd2: byte_sel = {4'h0, snap_state_q};
      3'd3: byte_sel = snap_acc_q[7:0];
      3'd4: byte_sel = snap_acc_q[15:8];
      3'd5: byte_sel = snap_acc_q[23:16];
      3'd6: byte_sel = snap_acc_q[31:24];
      3'd7: byte_sel = checksum;
      default: byte_sel = 8'h00;
    endcase
  end

  // Next-state and output logic. tx_valid/busy come straight from the state
  // register so an asynchronous reset drops them immediately. Triggers that
  // coincide in IDLE collapse into one frame; an auto trigger during SEND is
  // remembered in a one-deep pending flag and serviced on the first IDLE cycle.
  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    pending_d     = pending_q;
    load_snap     = 1'b0;
    frame_done_d  = 1'b0;
    req_dropped_d = 1'b0;
    busy          = 1'b0;
    tx_valid      = 1'b0;
    tx_data       = 8'h00;
    case (state_q)
      IDLE: begin
        if (result_req || auto_trig || pending_q) begin
          state_d   = SEND;
          idx_d     = 3'd0;
          pending_d = 1'b0;
          load_snap = 1'b1;
        end
      end
      SEND: begin
        busy     = 1'b1;
        tx_valid = 1'b1;
        tx_data  = byte_sel;
        if (auto_trig) begin
          pending_d = 1'b1;
        end
        if (result_req) begin
          req_dropped_d = 1'b1;
        end
        if (tx_ready) begin
          if (idx_q == 3'd7) begin
            state_d      = IDLE;
            idx_d        = 3'd0;
            frame_done_d = 1'b1;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, index, pending flag, edge-detect history, snapshot and the
  // registered status pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      idx_q        <= 3'd0;
      pending_q    <= 1'b0;
      prev_state_q <= 4'd0;
      snap_state_q <= 4'd0;
      snap_cnt_q   <= 5'd0;
      snap_acc_q   <= 32'd0;
      frame_done   <= 1'b0;
      req_dropped  <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      pending_q    <= pending_d;
      prev_state_q <= mlp_state_in;
      frame_done   <= frame_done_d;
      req_dropped  <= req_dropped_d;
      if (load_snap) begin
        snap_state_q <= mlp_state_in;
        snap_cnt_q   <= mlp_cycle_cnt_in;
        snap_acc_q   <= mlp_acc0_in;
      end
    end
  end

endmodule

// File: tb/tb_tpu_result_tx.sv
// Testbench for tpu_result_tx: a fixed vector table for the basic manual frame,
// hand-written sequences for backpressure, snapshot, auto-send, collisions and
// reset, and a randomized phase, all checked against a queue-based frame model.
module tb_tpu_result_tx;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        result_req = 1'b0;
  logic        auto_en = 1'b0;
  logic        tx_ready = 1'b0;
  logic [3:0]  mlp_state_in = 4'd0;
  logic [4:0]  mlp_cycle_cnt_in = 5'd0;
  logic [31:0] mlp_acc0_in = 32'd0;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        busy;
  logic        frame_done;
  logic        req_dropped;

  int n_checks = 0;
  int n_pass = 0;

  // Reference model: bytes still to be sent, one-deep pending flag, previous
  // MLP state and the pulses expected in the current cycle.
  logic [7:0] exp_q[$];
  logic       m_pend = 1'b0;
  logic [3:0] m_prev = 4'd0;
  logic       m_fd = 1'b0;
  logic       m_rd = 1'b0;

  typedef struct {
    logic       req;
    logic       rdy;
    logic       exp_valid;
    logic [7:0] exp_data;
    logic       exp_busy;
    logic       exp_fd;
  } vec_t;

  vec_t tbl[11];

  always #5 clk = ~clk;

  tpu_result_tx dut (
    .clk              (clk),
    .rst              (rst),
    .result_req       (result_req),
    .auto_en          (auto_en),
    .mlp_state_in     (mlp_state_in),
    .mlp_cycle_cnt_in (mlp_cycle_cnt_in),
    .mlp_acc0_in      (mlp_acc0_in),
    .tx_data          (tx_data),
    .tx_valid         (tx_valid),
    .tx_ready         (tx_ready),
    .busy             (busy),
    .frame_done       (frame_done),
    .req_dropped      (req_dropped)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    n_checks++;
    if (actual === expected) n_pass++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t",
                  name, actual, expected, $time);
  endtask

  task automatic applyStimulus(input logic req, input logic rdy, input logic aen,
                               input logic [3:0] st, input logic [4:0] cnt,
                               input logic [31:0] acc);
    result_req       = req;
    tx_ready         = rdy;
    auto_en          = aen;
    mlp_state_in     = st;
    mlp_cycle_cnt_in = cnt;
    mlp_acc0_in      = acc;
  endtask

  // Build the 8 frame bytes from the frame layout and queue them.
  task automatic pushFrame(input logic [3:0] st, input logic [4:0] cnt,
                           input logic [31:0] acc);
    logic [7:0]  b[8];
    logic [31:0] sh;
    b[0] = 8'hA5;
    b[1] = {3'b000, cnt};
    b[2] = {4'h0, st};
    for (int k = 0; k < 4; k++) begin
      sh = acc >> (8 * k);
      b[3 + k] = sh[7:0];
    end
    b[7] = b[1] ^ b[2] ^ b[3] ^ b[4] ^ b[5] ^ b[6];
    for (int k = 0; k < 8; k++) exp_q.push_back(b[k]);
  endtask

  task automatic modelReset();
    exp_q.delete();
    m_pend = 1'b0;
    m_prev = 4'd0;
    m_fd   = 1'b0;
    m_rd   = 1'b0;
  endtask

  // Compare DUT against the model mid-cycle, advance the model with the
  // inputs present at the coming rising edge, then move to the next negedge.
  task automatic tick();
    logic busy_m, auto_m, xfer_m, fd_n, rd_n;
    busy_m = (exp_q.size() != 0);
    checkOutput("busy", 32'(busy), 32'(busy_m));
    checkOutput("tx_valid", 32'(tx_valid), 32'(busy_m));
    checkOutput("tx_data", 32'(tx_data), 32'(busy_m ? exp_q[0] : 8'h00));
    checkOutput("frame_done", 32'(frame_done), 32'(m_fd));
    checkOutput("req_dropped", 32'(req_dropped), 32'(m_rd));
    auto_m = auto_en && (mlp_state_in == 4'd8) && (m_prev != 4'd8);
    xfer_m = busy_m && tx_ready;
    fd_n   = xfer_m && (exp_q.size() == 1);
    rd_n   = busy_m && result_req;
    if (busy_m) begin
      if (auto_m) m_pend = 1'b1;
      if (xfer_m) void'(exp_q.pop_front());
    end else if (result_req || auto_m || m_pend) begin
      pushFrame(mlp_state_in, mlp_cycle_cnt_in, mlp_acc0_in);
      m_pend = 1'b0;
    end
    m_prev = mlp_state_in;
    m_fd   = fd_n;
    m_rd   = rd_n;
    @(posedge clk);
    @(negedge clk);
  endtask

  // Run with the current inputs until every modelled frame (and pending one)
  // has gone out, then two idle cycles to observe frame_done.
  task automatic drainFrame(input int bound);
    int i = 0;
    while ((exp_q.size() != 0 || m_pend) && i < bound) begin
      tick();
      i++;
    end
    checkOutput("drain_bound", 32'(exp_q.size() == 0), 32'd1);
    tick();
    tick();
  endtask

  initial begin
    tbl[0]  = '{1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0};
    tbl[1]  = '{1'b0, 1'b1, 1'b1, 8'hA5, 1'b1, 1'b0};
    tbl[2]  = '{1'b0, 1'b1, 1'b1, 8'h11, 1'b1, 1'b0};
    tbl[3]  = '{1'b0, 1'b1, 1'b1, 8'h06, 1'b1, 1'b0};
    tbl[4]  = '{1'b0, 1'b1, 1'b1, 8'h78, 1'b1, 1'b0};
    tbl[5]  = '{1'b0, 1'b1, 1'b1, 8'h56, 1'b1, 1'b0};
    tbl[6]  = '{1'b0, 1'b1, 1'b1, 8'h34, 1'b1, 1'b0};
    tbl[7]  = '{1'b0, 1'b1, 1'b1, 8'h12, 1'b1, 1'b0};
    tbl[8]  = '{1'b0, 1'b1, 1'b1, 8'h1F, 1'b1, 1'b0};
    tbl[9]  = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1};
    tbl[10] = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0};

    // Reset state
    repeat (3) @(negedge clk);
    checkOutput("rst_tx_valid", 32'(tx_valid), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_tx_data", 32'(tx_data), 32'd0);
    checkOutput("rst_frame_done", 32'(frame_done), 32'd0);
    checkOutput("rst_req_dropped", 32'(req_dropped), 32'd0);
    rst = 1'b0;
    modelReset();

    // Manual frame from the vector table
    applyStimulus(1'b0, 1'b1, 1'b0, 4'd6, 5'd17, 32'h12345678);
    tick();
    tick();
    for (int i = 0; i < 11; i++) begin
      result_req = tbl[i].req;
      tx_ready   = tbl[i].rdy;
      checkOutput($sformatf("tbl%0d_valid", i), 32'(tx_valid), 32'(tbl[i].exp_valid));
      checkOutput($sformatf("tbl%0d_data", i), 32'(tx_data), 32'(tbl[i].exp_data));
      checkOutput($sformatf("tbl%0d_busy", i), 32'(busy), 32'(tbl[i].exp_busy));
      checkOutput($sformatf("tbl%0d_done", i), 32'(frame_done), 32'(tbl[i].exp_fd));
      tick();
    end

    // Backpressure with a 1,0,0,1 ready pattern
    applyStimulus(1'b1, 1'b1, 1'b0, 4'd6, 5'd17, 32'h12345678);
    tick();
    result_req = 1'b0;
    for (int i = 0; i < 64 && exp_q.size() != 0; i++) begin
      tx_ready = ((i % 4) == 0) || ((i % 4) == 3);
      tick();
    end
    checkOutput("bp_drained", 32'(exp_q.size() == 0), 32'd1);
    tx_ready = 1'b1;
    tick();
    tick();

    // Snapshot stability: acc0 changes after byte1 transfers
    applyStimulus(1'b1, 1'b1, 1'b0, 4'd6, 5'd17, 32'h12345678);
    tick();
    result_req = 1'b0;
    tick();
    tick();
    mlp_acc0_in = 32'hFFFF_FFFF;
    drainFrame(32);

    // Auto-send on 7 -> 8, no repeat while held, ignored with auto_en=0
    applyStimulus(1'b0, 1'b1, 1'b1, 4'd7, 5'd0, 32'hFFFF_FFFF);
    tick();
    tick();
    mlp_state_in = 4'd8;
    tick();
    drainFrame(32);
    repeat (10) tick();
    auto_en = 1'b0;
    mlp_state_in = 4'd7;
    tick();
    tick();
    mlp_state_in = 4'd8;
    repeat (12) tick();

    // Manual request mid-frame and on the final transfer cycle
    applyStimulus(1'b1, 1'b1, 1'b0, 4'd6, 5'd3, 32'hCAFE_0001);
    tick();
    result_req = 1'b0;
    tick();
    tick();
    result_req = 1'b1;
    tick();
    result_req = 1'b0;
    drainFrame(32);
    result_req = 1'b1;
    tick();
    result_req = 1'b0;
    repeat (7) tick();
    result_req = 1'b1;
    tick();
    result_req = 1'b0;
    drainFrame(32);

    // Auto edge mid-frame becomes a pending second frame
    applyStimulus(1'b1, 1'b1, 1'b1, 4'd7, 5'd9, 32'h8000_0000);
    tick();
    result_req = 1'b0;
    tick();
    tick();
    mlp_state_in = 4'd8;
    tick();
    drainFrame(48);

    // Manual and auto edge in the same idle cycle give one frame
    applyStimulus(1'b0, 1'b1, 1'b1, 4'd7, 5'd31, 32'h0F0F_F0F0);
    tick();
    result_req = 1'b1;
    mlp_state_in = 4'd8;
    tick();
    result_req = 1'b0;
    drainFrame(32);
    repeat (4) tick();

    // Reset while byte 4 is presented
    applyStimulus(1'b1, 1'b1, 1'b0, 4'd6, 5'd17, 32'h12345678);
    tick();
    result_req = 1'b0;
    repeat (4) tick();
    #2 rst = 1'b1;
    #1;
    checkOutput("midrst_tx_valid", 32'(tx_valid), 32'd0);
    checkOutput("midrst_busy", 32'(busy), 32'd0);
    checkOutput("midrst_tx_data", 32'(tx_data), 32'd0);
    modelReset();
    #1 rst = 1'b0;
    tick();
    result_req = 1'b1;
    tick();
    result_req = 1'b0;
    drainFrame(32);

    // Randomized traffic against the model
    for (int i = 0; i < 800; i++) begin
      result_req = ($urandom_range(0, 9) == 0);
      tx_ready   = ($urandom_range(0, 3) != 0);
      if ((i % 50) == 0) auto_en = 1'($urandom_range(0, 1));
      mlp_state_in = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) :
                     (($urandom_range(0, 1) == 1) ? 4'd8 : 4'd7);
      mlp_cycle_cnt_in = 5'($urandom);
      mlp_acc0_in      = $urandom;
      tick();
    end
    result_req = 1'b0;
    tx_ready   = 1'b1;
    drainFrame(64);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
